// File: rtl/regfile_pkg.sv
// Shared widths and types for the 32 x 32-bit MIPS-style register file.
package regfile_pkg;

    localparam int unsigned REG_W      = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_COUNT  = 32;

    localparam logic [4:0] ZERO_REG = 5'd0;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/regfile_read_port.sv
// One asynchronous read port: array mux, register-0 forcing and, when
// REGFILE_BYPASS_EN is defined, write-through forwarding from port 3.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [DATA_W-1:0] regs_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] ra_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wa_i,
    input  logic [DATA_W-1:0] wd_i,
    output logic [DATA_W-1:0] rd_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

`ifdef REGFILE_BYPASS_EN
    logic fwd_hit;

    // Forward only a write that will actually commit at the coming edge.
    assign fwd_hit = we_i && !rst_i && (wa_i != ZERO_ADDR) && (wa_i == ra_i);

    always_comb begin
        rd_o = regs_i[ra_i];
        if (fwd_hit) begin
            rd_o = wd_i;
        end
        if (ra_i == ZERO_ADDR) begin
            rd_o = '0;
        end
    end
`else
    logic unused_write_side;

    assign unused_write_side = ^{rst_i, we_i, wa_i, wd_i};

    always_comb begin
        rd_o = regs_i[ra_i];
        if (ra_i == ZERO_ADDR) begin
            rd_o = '0;
        end
    end
`endif

endmodule

// File: rtl/regfile.sv
// Three-port register file: two combinational reads, one synchronous write.
// Optional write-through forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = REG_W,
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              we3,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] wa3,
    input  logic [DATA_W-1:0] wd3,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int unsigned      DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic              wr_en_d;

    assign wr_en_d = we3 && (wa3 != ZERO_ADDR);

    // Reset is tested first so undefined write controls cannot reach the array.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[wa3] <= wd3;
        end
    end

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .regs_i (regs_q),
        .ra_i   (ra1),
        .rst_i  (rst),
        .we_i   (we3),
        .wa_i   (wa3),
        .wd_i   (wd3),
        .rd_o   (rd1)
    );

    regfile_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .regs_i (regs_q),
        .ra_i   (ra2),
        .rst_i  (rst),
        .we_i   (we3),
        .wa_i   (wa3),
        .wd_i   (wd3),
        .rd_o   (rd2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile; expected read values are queued when stimulus
// is applied and popped when the combinational outputs have settled.
module tb_regfile;
    import regfile_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      we3;
    reg_addr_t ra1;
    reg_addr_t ra2;
    reg_addr_t wa3;
    reg_data_t wd3;
    reg_data_t rd1;
    reg_data_t rd2;

    typedef struct {
        reg_data_t e1;
        reg_data_t e2;
    } exp_t;

    exp_t      sb_q[$];
    exp_t      ex;
    reg_data_t model [REG_COUNT];
    int        checks   = 0;
    int        failures = 0;

    always #5 clk = ~clk;

    regfile #(
        .DATA_W (REG_W),
        .ADDR_W (REG_ADDR_W)
    ) dut (
        .clk (clk),
        .we3 (we3),
        .rst (rst),
        .ra1 (ra1),
        .ra2 (ra2),
        .wa3 (wa3),
        .wd3 (wd3),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    function automatic reg_data_t ref_rd(reg_addr_t ra);
        return (ra == 5'd0) ? 32'h0 : model[ra];
    endfunction

    function automatic reg_data_t ref_fwd(reg_addr_t ra);
`ifdef REGFILE_BYPASS_EN
        if (we3 === 1'b1 && rst === 1'b0 && wa3 != 5'd0 && wa3 == ra) return wd3;
`endif
        return ref_rd(ra);
    endfunction

    // Apply the current inputs to the model, then let the DUT take the edge.
    task automatic clock_edge();
        if (rst === 1'b1) begin
            for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
        end else if (we3 === 1'b1 && wa3 != 5'd0) begin
            model[wa3] = wd3;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; we3 = 1'bx; wa3 = 'x; wd3 = 'x; ra1 = '0; ra2 = '0;
        clock_edge();
        rst = 1'b0; we3 = 1'b0; wa3 = '0; wd3 = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            ra1 = reg_addr_t'(i);
            ra2 = reg_addr_t'(REG_COUNT - 1 - i);
            sb_q.push_back('{e1: 32'h0, e2: 32'h0});
            #1;
            ex = sb_q.pop_front();
            checks += 2;
            if (rd1 !== ex.e1) begin
                failures++;
                $display("FAIL reset rd1[%0d] got=%h exp=%h", ra1, rd1, ex.e1);
            end
            if (rd2 !== ex.e2) begin
                failures++;
                $display("FAIL reset rd2[%0d] got=%h exp=%h", ra2, rd2, ex.e2);
            end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h6;
        clock_edge();
        @(negedge clk);
        wa3 = 5'd9; wd3 = 32'h3;
        clock_edge();
        @(negedge clk);
        we3 = 1'b0; ra1 = 5'd8; ra2 = 5'd9;
        sb_q.push_back('{e1: 32'h6, e2: 32'h3});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL write_read rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL write_read rd2 got=%h exp=%h", rd2, ex.e2);
        end
    endtask

    task automatic test_we_low();
        @(negedge clk);
        we3 = 1'b0; wa3 = 5'd8; wd3 = 32'hFF; ra1 = 5'd8; ra2 = 5'd9;
        clock_edge();
        sb_q.push_back('{e1: 32'h6, e2: 32'h3});
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL we_low rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL we_low rd2 got=%h exp=%h", rd2, ex.e2);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'hDEADBEEF; ra1 = 5'd0; ra2 = 5'd0;
        sb_q.push_back('{e1: 32'h0, e2: 32'h0});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL zero_pre rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL zero_pre rd2 got=%h exp=%h", rd2, ex.e2);
        end
        clock_edge();
        we3 = 1'b0;
        sb_q.push_back('{e1: 32'h0, e2: 32'h0});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL zero_post rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL zero_post rd2 got=%h exp=%h", rd2, ex.e2);
        end
    endtask

    task automatic test_reset_priority();
        @(negedge clk);
        rst = 1'b1; we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h7; ra1 = 5'd8; ra2 = 5'd9;
        // reset gates forwarding, so the stored values are still visible here
        sb_q.push_back('{e1: 32'h6, e2: 32'h3});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL rst_prio_pre rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL rst_prio_pre rd2 got=%h exp=%h", rd2, ex.e2);
        end
        clock_edge();
        rst = 1'b0; we3 = 1'b0;
        sb_q.push_back('{e1: 32'h0, e2: 32'h0});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL rst_prio_post rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL rst_prio_post rd2 got=%h exp=%h", rd2, ex.e2);
        end
    endtask

    task automatic test_same_cycle();
        reg_data_t pre1;
        reg_data_t pre2;
`ifdef REGFILE_BYPASS_EN
        pre1 = 32'h1234; pre2 = 32'hABCD;
`else
        pre1 = 32'h0;    pre2 = 32'h0;
`endif
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'h1234; ra1 = 5'd5; ra2 = 5'd5;
        sb_q.push_back('{e1: pre1, e2: pre1});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL same_pre rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL same_pre rd2 got=%h exp=%h", rd2, ex.e2);
        end
        clock_edge();
        we3 = 1'b0;
        sb_q.push_back('{e1: 32'h1234, e2: 32'h1234});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL same_post rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL same_post rd2 got=%h exp=%h", rd2, ex.e2);
        end
        @(negedge clk);
        we3 = 1'b1; wa3 = 5'd6; wd3 = 32'hABCD; ra1 = 5'd3; ra2 = 5'd6;
        sb_q.push_back('{e1: 32'h0, e2: pre2});
        #1;
        ex = sb_q.pop_front();
        checks += 2;
        if (rd1 !== ex.e1) begin
            failures++;
            $display("FAIL port2_pre rd1 got=%h exp=%h", rd1, ex.e1);
        end
        if (rd2 !== ex.e2) begin
            failures++;
            $display("FAIL port2_pre rd2 got=%h exp=%h", rd2, ex.e2);
        end
        clock_edge();
        we3 = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            we3 = 1'($urandom_range(0, 3) != 0);
            wa3 = reg_addr_t'($urandom_range(0, 31));
            wd3 = $urandom;
            ra1 = ($urandom_range(0, 2) == 0) ? wa3 : reg_addr_t'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 2) == 0) ? wa3 : reg_addr_t'($urandom_range(0, 31));
            sb_q.push_back('{e1: ref_fwd(ra1), e2: ref_fwd(ra2)});
            #1;
            ex = sb_q.pop_front();
            checks += 2;
            if (rd1 !== ex.e1) begin
                failures++;
                $display("FAIL b2b_pre n=%0d rd1[%0d] got=%h exp=%h", n, ra1, rd1, ex.e1);
            end
            if (rd2 !== ex.e2) begin
                failures++;
                $display("FAIL b2b_pre n=%0d rd2[%0d] got=%h exp=%h", n, ra2, rd2, ex.e2);
            end
            clock_edge();
            sb_q.push_back('{e1: ref_fwd(ra1), e2: ref_fwd(ra2)});
            ex = sb_q.pop_front();
            checks += 2;
            if (rd1 !== ex.e1) begin
                failures++;
                $display("FAIL b2b_post n=%0d rd1[%0d] got=%h exp=%h", n, ra1, rd1, ex.e1);
            end
            if (rd2 !== ex.e2) begin
                failures++;
                $display("FAIL b2b_post n=%0d rd2[%0d] got=%h exp=%h", n, ra2, rd2, ex.e2);
            end
        end
        @(negedge clk);
        rst = 1'b0; we3 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
        for (int i = 0; i < REG_COUNT; i++) model[i] = '0;
        test_reset();
        test_write_read();
        test_we_low();
        test_zero_reg();
        test_reset_priority();
        test_same_cycle();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile.md
# regfile

Three-port register file for the pipelined MIPS-style processor: 32 registers × 32 bits, two asynchronous read ports and one synchronous write port. It sits in the decode stage, which reads operands through it. The writeback stage commits results through it. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W = 32

Ports (positional order is clk, we3, rst, ra1, ra2, wa3, wd3, rd1, rd2):
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  reset, synchronous and active-high; clears every register
- we3  input  1  write enable for port 3
- ra1  input  ADDR_W  read address, port 1
- ra2  input  ADDR_W  read address, port 2
- wa3  input  ADDR_W  write address, port 3
- wd3  input  DATA_W  write data, port 3
- rd1  output  DATA_W  read data, port 1
- rd2  output  DATA_W  read data, port 2

## Operation
- Storage: 32 × DATA_W flops.
- Reset:
  - On a rising clk edge with rst=1, all registers become 0.
  - Reset has priority over a write in the same cycle.
- Write:
  - On a rising clk edge with rst=0 and we3=1, reg[wa3] ← wd3.
  - we3=0 leaves the array unchanged.
- Register 0:
  - Writes with wa3=0 are discarded.
  - Reads of address 0 always return 0, independent of reset history.
- Read:
  - rd1 = reg[ra1] and rd2 = reg[ra2], purely combinational with no clock involved.
  - Both ports may address the same register, and both return the same value.
- X/undefined control inputs while rst=1 must not corrupt the post-reset state (all zeros).

## Timing
- Write latency: one edge. Data is visible on rd1/rd2 immediately after the edge that writes it.
- Read latency: zero cycles (combinational path from ra1/ra2 to rd1/rd2).
- Output values:
  - Before the first reset edge, the contents of registers 1–31 are undefined.
  - After the reset edge, rd1/rd2 = 0 for every address.
- Reset mid-operation: rst asserted at any edge clears all contents. A pending write at that edge is dropped.
- Simultaneous read and write of the same nonzero address, without bypass: rd returns the old value until the edge and the new value after it.

## Configuration
- REGFILE_BYPASS_EN
  - Defined: write-through forwarding.
    - Applies when we3=1, rst=0, wa3≠0 and ra1==wa3 (respectively ra2==wa3).
    - In that case rd1 (respectively rd2) = wd3 combinationally, in the same cycle as the write.
    - This removes the writeback→decode hazard.
  - Undefined: no forwarding. Reads return only the stored contents.

## Structure
- Shared package regfile_pkg:
  - REG_W=32, REG_ADDR_W=5, REG_COUNT=32
  - ZERO_REG=5'd0
  - typedef reg_addr_t (logic [4:0]), typedef reg_data_t (logic [31:0])
- Optional sub-module regfile_read_port, instantiated once per read port:
  - Address decode/mux.
  - Zero-register forcing.
  - Bypass compare when REGFILE_BYPASS_EN is defined.
- The write and reset logic stays in the top level.

## Test plan
- rst=1 for one edge, then read addresses 0, 8 and 31 → rd1=rd2=0.
- we3=1, wa3=8, wd3=0x6, one edge; then we3=1, wa3=9, wd3=0x3, one edge; then ra1=8, ra2=9 → rd1=0x6, rd2=0x3.
- Starting with reg[8]=0x6: we3=0, wa3=8, wd3=0xFF, one edge → ra1=8 still reads 0x6.
- we3=1, wa3=0, wd3=0xDEADBEEF, one edge → ra1=0 reads 0.
- Starting with reg[8]=0x6, reg[9]=0x3: rst=1 and we3=1 (wa3=8, wd3=0x7) at the same edge → rd1(ra1=8)=0 and rd2(ra2=9)=0 after the edge.
- Starting with reg[5]=0: we3=1, wa3=5, wd3=0x1234 with ra1=5, checked before the edge:
  - With REGFILE_BYPASS_EN → rd1=0x1234.
  - Without → rd1 keeps the old value (0) until the edge, then 0x1234.
